uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLOCK, default 50, system clock frequency in MHz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit queue depth in bytes; legal values are powers of two, 2..16.
REQ-004 SHALL have port clk, input, 1 bit, system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, reset, synchronous, active-low.
REQ-006 SHALL have port tx_data, input, 8 bits, byte offered by the core.
REQ-007 SHALL have port tx_valid, input, 1 bit, tx_data is offered this cycle.
REQ-008 SHALL have port tx_ready, output, 1 bit, the FIFO can accept a byte this cycle.
REQ-009 SHALL have port txd, output, 1 bit, serial line (idle high).
REQ-010 SHALL have port busy, output, 1 bit, a frame is in progress or the FIFO is non-empty.
REQ-011 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits, number of queued bytes.

Function
REQ-012 SHALL compute DIV = (CLOCK*1000000)/BAUD with integer truncation at elaboration (434 for the defaults); every bit period is exactly DIV clk cycles.
REQ-013 SHALL transmit 8N1 frames: one start bit (0), eight data bits LSB first, and one stop bit (1), for 10*DIV cycles per frame.
REQ-014 SHALL accept a byte into the FIFO on any rising edge where tx_valid && tx_ready; tx_data is ignored whenever tx_ready = 0.
REQ-015 SHALL drive tx_ready = (fifo_count != FIFO_DEPTH) from registered state only, with no combinational path from tx_valid.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP, with a baud counter 0..DIV-1 and a bit index 0..7.
REQ-017 SHALL, in IDLE with the FIFO non-empty, pop the head byte into the shift register and enter START on the same edge; txd goes low after that edge.
REQ-018 SHALL make the latency from the accepting edge (empty FIFO, IDLE) to txd falling exactly 2 clock edges: edge 1 writes the FIFO, edge 2 pops it and enters START.
REQ-019 SHALL advance START->DATA, DATA bit n->n+1, DATA bit 7->STOP, and STOP->next state each time the baud counter reaches DIV-1; the counter then wraps to 0.
REQ-020 SHALL, at the end of STOP with the FIFO non-empty, pop and enter START directly, so back-to-back frames have no idle gap; with the FIFO empty it SHALL enter IDLE.
REQ-021 SHALL handle a push and a pop on the same edge with fifo_count unchanged and data order preserved.
REQ-022 SHALL, when the FIFO is full and a pop occurs, raise tx_ready only in the cycle after the pop; a tx_valid asserted during the pop cycle is not accepted.
REQ-023 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH and never underflows.
REQ-024 SHALL drive busy = (state != IDLE) || (fifo_count != 0), registered or derived from registered state only.
REQ-025 SHALL drive txd from a flip-flop (glitch-free) and hold it at 1 in IDLE.

Reset
REQ-026 SHALL, while rst_n = 0 at a clock edge, set txd = 1, tx_ready = 1, busy = 0, fifo_count = 0, state = IDLE, baud counter = 0, bit index = 0, and both FIFO pointers = 0.
REQ-027 SHALL, on reset mid-frame, abort the frame and flush the FIFO; txd returns to 1 after that edge, and no partial frame resumes after rst_n is released.
REQ-028 SHALL ignore tx_valid while rst_n = 0.

Verification (use CLOCK=1 and BAUD=250000, so DIV=4, unless stated)
REQ-029 SHALL cover a single byte 0x55 pushed while idle: txd falls 2 edges after acceptance, then runs 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles wide, then busy drops.
REQ-030 SHALL cover 4 bytes 0xA5, 0x00, 0xFF, 0x3C pushed on consecutive cycles: 4 frames back-to-back in order, 40 bit periods with no idle gap, and fifo_count peaking at 3.
REQ-031 SHALL cover tx_valid held high with 6 distinct bytes: bytes 1-5 are accepted (one in flight plus 4 queued), tx_ready drops, byte 6 is accepted 1 cycle after the next pop, and all 6 appear in order on txd.
REQ-032 SHALL cover rst_n pulled low for 1 cycle during data bit 3 with 2 bytes queued: txd = 1 next cycle, fifo_count = 0, busy = 0, and no further frames.
REQ-033 SHALL cover a simultaneous push and pop at the STOP->START boundary with fifo_count = 2: fifo_count stays 2 and the byte order on txd is preserved.
REQ-034 SHALL cover the default parameters with byte 0x80: each bit is 434 cycles wide and the frame is 4340 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing fed from a small byte FIFO.
// The bit period is fixed at elaboration from the CLOCK (MHz) and BAUD parameters.
module uart_tx #(
    parameter int CLOCK      = 50,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV     = (CLOCK * 1000000) / BAUD;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]   BAUD_LAST  = CNT_W'(DIV - 1);
    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         data_q, data_d;
    logic               txd_q, txd_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];

    logic push_s;
    logic pop_s;
    logic tick_s;
    logic empty_s;

    // Frame sequencer: pops the FIFO head and walks start, data and stop bits.
    always_comb begin
        push_s  = tx_valid && ready_q;
        tick_s  = (baud_q == BAUD_LAST);
        empty_s = (count_q == COUNT_W'(0));
        pop_s   = 1'b0;
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        txd_d   = txd_q;
        case (state_q)
            IDLE: begin
                baud_d = CNT_W'(0);
                bit_d  = 3'd0;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    state_d = START;
                    txd_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            end
            START: begin
                if (tick_s) begin
                    baud_d  = CNT_W'(0);
                    bit_d   = 3'd0;
                    state_d = DATA;
                    txd_d   = data_q[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (tick_s) begin
                    baud_d = CNT_W'(0);
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = data_q[bit_d];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (tick_s) begin
                    baud_d = CNT_W'(0);
                    bit_d  = 3'd0;
                    // Chain straight into the next frame so there is no idle gap.
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        data_d  = mem_q[rd_ptr_q];
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = CNT_W'(0);
                bit_d   = 3'd0;
                txd_d   = 1'b1;
            end
        endcase
    end

    // FIFO bookkeeping; ready and busy are precomputed so outputs come straight from flops.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push_s && (wr_ptr_q == PTR_W'(i))) begin
                mem_d[i] = tx_data;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != COUNT_FULL);
        busy_d  = (state_d != IDLE) || (count_d != COUNT_W'(0));
    end

    // State registers with synchronous active-low reset that aborts any frame and flushes the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= CNT_W'(0);
            bit_q    <= 3'd0;
            data_q   <= 8'h00;
            txd_q    <= 1'b1;
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= COUNT_W'(0);
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            mem_q    <= '{default: 8'h00};
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            txd_q    <= txd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            mem_q    <= mem_d;
        end
    end

    assign txd        = txd_q;
    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int DIVT  = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, txd, busy;
    logic [2:0] fifo_count;

    logic [7:0] d_data;
    logic       d_valid;
    logic       d_ready, d_txd, d_busy;
    logic [2:0] d_count;

    always #5 clk = ~clk;

    uart_tx #(.CLOCK(1), .BAUD(250000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .txd(txd), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx dut_def (
        .clk(clk), .rst_n(rst_n), .tx_data(d_data), .tx_valid(d_valid),
        .tx_ready(d_ready), .txd(d_txd), .busy(d_busy), .fifo_count(d_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a byte queue and one in-flight frame tracked by its cycle offset.
    logic [7:0] m_q[$];
    bit         m_act = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_acc = 1'b0;
    bit         m_rdy;
    bit         cmp_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_act = 1'b0;
            m_pos = 0;
            m_acc = 1'b0;
        end else begin
            m_rdy = (m_q.size() != DEPTH);
            m_acc = tx_valid && m_rdy;
            if (m_act && (m_pos + 1 < 10 * DIVT)) begin
                m_pos++;
            end else if (m_q.size() != 0) begin
                m_byte = m_q.pop_front();
                m_act  = 1'b1;
                m_pos  = 0;
            end else begin
                m_act = 1'b0;
                m_pos = 0;
            end
            if (m_acc) m_q.push_back(tx_data);
        end
    end

    function automatic logic m_txd();
        int k;
        if (!m_act) return 1'b1;
        k = m_pos / DIVT;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_txd", txd, m_txd());
            chk("model_ready", tx_ready, (m_q.size() != DEPTH));
            chk("model_busy", busy, (m_act || (m_q.size() != 0)));
            chk("model_count", fifo_count, m_q.size());
        end
    end

    // Line capture for byte decoding and peak/busy statistics.
    logic       line_log[$];
    bit         log_en = 1'b0;
    int         peak = 0;
    int         busy_cnt = 0;
    logic [7:0] rx[$];
    logic [7:0] exp_rx[$];

    always @(negedge clk) begin
        if (log_en) begin
            line_log.push_back(txd);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (busy === 1'b1) busy_cnt++;
        end
    end

    task automatic start_log();
        line_log.delete();
        peak     = 0;
        busy_cnt = 0;
        log_en   = 1'b1;
    endtask

    task automatic decode();
        int i = 0;
        logic [7:0] b;
        rx.delete();
        while (i + 40 <= line_log.size()) begin
            if (line_log[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = line_log[i + 4 * (k + 1) + 2];
                chk("stop_bit", line_log[i + 38], 1);
                rx.push_back(b);
                i += 40;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_rx(input string name);
        log_en = 1'b0;
        decode();
        chk({name, "_nbytes"}, rx.size(), exp_rx.size());
        for (int k = 0; k < exp_rx.size() && k < rx.size(); k++) chk(name, rx[k], exp_rx[k]);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_in_time"}, (n < limit), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int acc;
        int cyc;
        int acc6;
        int lows;
        int high;
        logic [9:0] pat;
        logic [7:0] bytes6 [6];

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; d_valid = 1'b0; d_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_def_txd", d_txd, 1);
        chk("rst_def_ready", d_ready, 1);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single 0x55 frame from idle
        start_log();
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 1;
        while (txd !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t1_latency", n, 2);
        pat = 10'b1010101010;
        for (int k = 0; k < 40; k++) begin
            chk("t1_bit", txd, pat[k / 4]);
            @(negedge clk);
        end
        chk("t1_busy_drop", busy, 0);
        exp_rx = '{8'h55};
        check_rx("t1_bytes");
        repeat (2) @(negedge clk);

        // Four bytes on consecutive cycles, back-to-back frames
        start_log();
        tx_valid = 1'b1; tx_data = 8'hA5;
        @(negedge clk); tx_data = 8'h00;
        @(negedge clk); tx_data = 8'hFF;
        @(negedge clk); tx_data = 8'h3C;
        @(negedge clk); tx_valid = 1'b0;
        wait_idle("t2", 400);
        chk("t2_peak", peak, 3);
        chk("t2_busy_cycles", busy_cnt, 161);
        exp_rx = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
        check_rx("t2_bytes");

        // tx_valid held high with six bytes, FIFO fills
        bytes6 = '{8'h01, 8'h82, 8'h43, 8'hC4, 8'h25, 8'hE6};
        start_log();
        acc = 0; cyc = 0; acc6 = 0;
        tx_valid = 1'b1; tx_data = bytes6[0];
        while (acc < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5)  chk("t3_ready_low", tx_ready, 0);
            if (cyc == 41) chk("t3_ready_still_low", tx_ready, 0);
            if (cyc == 42) chk("t3_ready_back", tx_ready, 1);
            if (m_acc) begin
                acc++;
                if (acc == 6) acc6 = cyc;
                if (acc < 6) tx_data = bytes6[acc];
                else tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0;
        chk("t3_accepts", acc, 6);
        chk("t3_byte6_edge", acc6, 43);
        wait_idle("t3", 400);
        exp_rx = '{8'h01, 8'h82, 8'h43, 8'hC4, 8'h25, 8'hE6};
        check_rx("t3_bytes");

        // Reset during data bit 3 with two bytes queued
        tx_valid = 1'b1; tx_data = 8'h12;
        @(negedge clk); tx_data = 8'h34;
        @(negedge clk); tx_data = 8'h56;
        @(negedge clk); tx_valid = 1'b0;
        repeat (16) @(negedge clk);
        chk("t4_bit3", txd, 0);
        chk("t4_queued", fifo_count, 2);
        rst_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h99;
        @(negedge clk);
        chk("t4_txd", txd, 1);
        chk("t4_count", fifo_count, 0);
        chk("t4_busy", busy, 0);
        chk("t4_ready", tx_ready, 1);
        rst_n = 1'b1; tx_valid = 1'b0;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        chk("t4_no_resume", lows, 0);
        chk("t4_busy_after", busy, 0);

        // Push and pop together at the STOP->START boundary
        start_log();
        tx_valid = 1'b1; tx_data = 8'h11;
        @(negedge clk); tx_data = 8'h22;
        @(negedge clk); tx_data = 8'h33;
        @(negedge clk); tx_valid = 1'b0;
        repeat (38) @(negedge clk);
        chk("t5_count_pre", fifo_count, 2);
        tx_valid = 1'b1; tx_data = 8'h44;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t5_count_post", fifo_count, 2);
        chk("t5_start", txd, 0);
        wait_idle("t5", 400);
        exp_rx = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_rx("t5_bytes");

        // Default parameters, 0x80: 434-cycle bits, 4340-cycle frame
        d_data = 8'h80; d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        n = 1;
        while (d_txd !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t6_latency", n, 2);
        lows = 0;
        while (d_txd === 1'b0 && lows < 5000) begin
            lows++;
            @(negedge clk);
        end
        chk("t6_low_run", lows, 3472);
        high = 0;
        while (d_busy === 1'b1 && high < 2000) begin
            high++;
            @(negedge clk);
        end
        chk("t6_high_run", high, 868);
        chk("t6_frame_len", lows + high, 4340);
        chk("t6_idle_txd", d_txd, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
